// File: rtl/mesh_rsc_inj_arbiter_if.sv
// Bundle between the resource cluster requesters, the injection arbiter and
// one mesh node's resource injection slice (packet, write, full, overflow).
interface mesh_rsc_inj_arbiter_if #(
   parameter int REQ_N       = 4,
   parameter int ROW_N       = 3,
   parameter int COL_M       = 3,
   parameter int PCKT_DATA_W = 8,
   parameter int CNT_W       = 8
);
   localparam int ROW_ADDR_W = $clog2(ROW_N);
   localparam int COL_ADDR_W = $clog2(COL_M);
   localparam int PCKT_W     = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W;

   // requester side
   logic [REQ_N-1:0]             req_i;
   logic [REQ_N*PCKT_DATA_W-1:0] req_data_i;
   logic [REQ_N*ROW_ADDR_W-1:0]  req_row_i;
   logic [REQ_N*COL_ADDR_W-1:0]  req_col_i;
   logic [REQ_N-1:0]             gnt_o;
   // node side
   logic [PCKT_W-1:0]            pckt_o;
   logic                         wren_o;
   logic                         noc_full_i;
   logic                         noc_ovrflw_i;
   // status
   logic                         busy_o;
   logic                         drop_o;
   logic [CNT_W-1:0]             drop_cnt_o;

   // arbiter view
   modport slave (
      input  req_i, req_data_i, req_row_i, req_col_i, noc_full_i, noc_ovrflw_i,
      output gnt_o, pckt_o, wren_o, busy_o, drop_o, drop_cnt_o
   );

   // requester / node view
   modport master (
      output req_i, req_data_i, req_row_i, req_col_i, noc_full_i, noc_ovrflw_i,
      input  gnt_o, pckt_o, wren_o, busy_o, drop_o, drop_cnt_o
   );
endinterface

// File: rtl/mesh_rsc_inj_arbiter.sv
// Round-robin injection arbiter for one mesh node's resource channel.
// Grants one requester, writes its {data,row,col} packet as a single-cycle
// pulse, watches the overflow flag in the following cycle and replays the
// same packet up to MAX_RETRY times before abandoning it.
module mesh_rsc_inj_arbiter #(
   parameter int REQ_N       = 4,
   parameter int ROW_N       = 3,
   parameter int COL_M       = 3,
   parameter int PCKT_DATA_W = 8,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   mesh_rsc_inj_arbiter_if.slave bus
);
   localparam int ROW_ADDR_W = $clog2(ROW_N);
   localparam int COL_ADDR_W = $clog2(COL_M);
   localparam int PCKT_W     = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W;
   localparam int PTR_W      = $clog2(REQ_N);
   localparam int RTY_W      = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, CHECK, RETRY} state_t;

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [RTY_W-1:0]  retry;
   logic [PCKT_W-1:0] pckt;
   logic              wren;
   logic              drop;
   logic [CNT_W-1:0]  drop_cnt;

   logic [PTR_W-1:0]  win;
   logic              win_vld;
   logic              grant;
   logic [PCKT_W-1:0] win_pckt;

   // first active requester at or after the pointer, wrapping circularly
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = 0; i < REQ_N; i++) begin
         automatic int j = int'(ptr) + i;
         if (j >= REQ_N) j = j - REQ_N;
         if (!win_vld && bus.req_i[j]) begin
            win_vld = 1'b1;
            win     = PTR_W'(j);
         end
      end
   end

   // a grant is only possible from IDLE with room in the node FIFO;
   // gated by reset so the grant reads zero while reset is held
   assign grant    = rst_ni && (state == IDLE) && !bus.noc_full_i && win_vld;
   assign win_pckt = {bus.req_data_i[win*PCKT_DATA_W +: PCKT_DATA_W],
                      bus.req_row_i[win*ROW_ADDR_W +: ROW_ADDR_W],
                      bus.req_col_i[win*COL_ADDR_W +: COL_ADDR_W]};

   assign bus.gnt_o      = grant ? (REQ_N'(1) << win) : '0;
   assign bus.pckt_o     = pckt;
   assign bus.wren_o     = wren;
   assign bus.drop_o     = drop;
   assign bus.drop_cnt_o = drop_cnt;
   assign bus.busy_o     = (state != IDLE);

   // control FSM: capture on grant, check overflow after each write, replay or drop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         ptr      <= '0;
         retry    <= '0;
         pckt     <= '0;
         wren     <= 1'b0;
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         wren <= 1'b0;
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  pckt  <= win_pckt;
                  wren  <= 1'b1;
                  ptr   <= (win == PTR_W'(REQ_N - 1)) ? '0 : win + 1'b1;
                  retry <= '0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (!bus.noc_ovrflw_i) begin
                  state <= IDLE;
               end else if (retry < RTY_W'(MAX_RETRY)) begin
                  state <= RETRY;
               end else begin
                  // out of replays: abandon the packet and count it
                  drop  <= 1'b1;
                  if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                  state <= IDLE;
               end
            end
            RETRY: begin
               // pckt is untouched, so the replay carries the same packet
               if (!bus.noc_full_i) begin
                  wren  <= 1'b1;
                  retry <= retry + 1'b1;
                  state <= CHECK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mesh_rsc_inj_arbiter.sv
// Bench for the mesh resource injection arbiter: a packet-level model
// (packet owned / attempts made / last cycle wrote) checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_mesh_rsc_inj_arbiter;
   localparam int REQ_N = 4, ROW_N = 3, COL_M = 3, DW = 8, MAX_RETRY = 3, CNT_W = 8;
   localparam int RW = 2, CW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   mesh_rsc_inj_arbiter_if #(.REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M),
                             .PCKT_DATA_W(DW), .CNT_W(CNT_W)) bus ();

   mesh_rsc_inj_arbiter #(.REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M),
                          .PCKT_DATA_W(DW), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W))
      dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- packet-level model ----------------
   bit          m_have  = 0;   // a packet is owned (being written or replayed)
   bit          m_wrote = 0;   // a write pulse is visible this cycle
   bit          m_drop  = 0;
   int          m_att   = 0;   // write attempts made for the owned packet
   int          m_ptr   = 0;
   int          m_drops = 0;
   logic [11:0] m_pkt   = '0;

   function automatic int pick();
      if (bus.noc_full_i || bus.req_i == '0) return -1;
      for (int i = 0; i < REQ_N; i++) begin
         int j = (m_ptr + i) % REQ_N;
         if (bus.req_i[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_have = 0; m_wrote = 0; m_drop = 0; m_att = 0; m_ptr = 0; m_drops = 0; m_pkt = '0;
      end else begin
         bit wr;
         int w;
         wr = 0;
         m_drop = 0;
         if (!m_have) begin
            w = pick();
            if (w >= 0) begin
               m_have = 1;
               m_att  = 1;
               m_pkt  = {bus.req_data_i[w*DW +: DW], bus.req_row_i[w*RW +: RW], bus.req_col_i[w*CW +: CW]};
               m_ptr  = (w + 1) % REQ_N;
               wr     = 1;
            end
         end else if (m_wrote) begin
            if (!bus.noc_ovrflw_i) m_have = 0;
            else if (m_att > MAX_RETRY) begin
               m_have = 0;
               m_drop = 1;
               if (m_drops < 255) m_drops++;
            end
         end else if (!bus.noc_full_i) begin
            wr = 1;
            m_att++;
         end
         m_wrote = wr;
      end
   end

   // ---------------- checking ----------------
   int q_win[$];
   int q_cyc[$];
   int wren_cnt = 0;
   int drop_seen = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      int w;
      logic [3:0] eg;
      w  = pick();
      eg = '0;
      if (rst_n && !m_have && w >= 0) eg = 4'(1 << w);
      chk("gnt",      32'(bus.gnt_o),      32'(eg));
      chk("wren",     32'(bus.wren_o),     32'(m_wrote));
      chk("pckt",     32'(bus.pckt_o),     32'(m_pkt));
      chk("busy",     32'(bus.busy_o),     32'(m_have));
      chk("drop",     32'(bus.drop_o),     32'(m_drop));
      chk("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drops));
      for (int i = 0; i < REQ_N; i++)
         if (bus.gnt_o[i]) begin q_win.push_back(i); q_cyc.push_back(cyc); end
      if (bus.wren_o) wren_cnt++;
      if (bus.drop_o) drop_seen++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_slot(int k, logic [7:0] d, logic [1:0] r, logic [1:0] c);
      bus.req_data_i[k*DW +: DW] = d;
      bus.req_row_i[k*RW +: RW]  = r;
      bus.req_col_i[k*CW +: CW]  = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req_i = '0; bus.req_data_i = '0; bus.req_row_i = '0; bus.req_col_i = '0;
      bus.noc_full_i = 1'b0; bus.noc_ovrflw_i = 1'b0;
      fork
         forever begin
            @(negedge clk);
            compare();
         end
         begin : stim
            int qb, wb, db;
            #1 rst_n = 1'b0;
            step(); step();
            chk("rst_busy",     32'(bus.busy_o),     32'd0);
            chk("rst_wren",     32'(bus.wren_o),     32'd0);
            chk("rst_drop_cnt", 32'(bus.drop_cnt_o), 32'd0);
            rst_n = 1'b1;
            step();

            // single requester
            set_slot(2, 8'hA5, 2'd2, 2'd1);
            bus.req_i = 4'b0100;
            @(negedge clk); #1;
            chk("single_gnt", 32'(bus.gnt_o), 32'h4);
            step();
            bus.req_i = '0;
            @(negedge clk); #1;
            chk("single_wren", 32'(bus.wren_o), 32'd1);
            chk("single_pckt", 32'(bus.pckt_o), 32'hA59);
            step();
            @(negedge clk); #1;
            chk("single_wren_low", 32'(bus.wren_o), 32'd0);
            step();

            // fairness, all requesters held
            do_reset();
            for (int k = 0; k < REQ_N; k++) set_slot(k, 8'(8'h10 + k), 2'(k % 3), 2'((k + 1) % 3));
            qb = q_win.size();
            bus.req_i = 4'hF;
            repeat (9) step();
            bus.req_i = '0;
            step(); step();
            chk("fair_count", 32'(q_win.size() - qb), 32'd5);
            if (q_win.size() - qb == 5) begin
               int exp_order[5] = '{0, 1, 2, 3, 0};
               for (int i = 0; i < 5; i++) chk("fair_order", 32'(q_win[qb + i]), 32'(exp_order[i]));
               for (int i = 0; i < 4; i++) chk("fair_gap", 32'(q_cyc[qb + i + 1] - q_cyc[qb + i]), 32'd2);
            end

            // backpressure
            do_reset();
            qb = q_win.size(); wb = wren_cnt;
            set_slot(1, 8'h77, 2'd1, 2'd0);
            bus.noc_full_i = 1'b1;
            bus.req_i = 4'b0010;
            repeat (5) step();
            chk("bp_no_gnt",  32'(q_win.size() - qb), 32'd0);
            chk("bp_no_wren", 32'(wren_cnt - wb),     32'd0);
            bus.noc_full_i = 1'b0;
            @(negedge clk); #1;
            chk("bp_gnt", 32'(bus.gnt_o), 32'h2);
            step();
            bus.req_i = '0;
            @(negedge clk); #1;
            chk("bp_pckt", 32'(bus.pckt_o), 32'h774);
            step(); step();

            // single replay
            do_reset();
            wb = wren_cnt;
            set_slot(0, 8'h3C, 2'd1, 2'd2);
            bus.req_i = 4'b0001;
            step();
            bus.req_i = '0;
            bus.noc_ovrflw_i = 1'b1;
            step();
            bus.noc_ovrflw_i = 1'b0;
            bus.noc_full_i = 1'b1;
            step();
            bus.noc_full_i = 1'b0;
            step();
            @(negedge clk); #1;
            chk("replay_wren", 32'(bus.wren_o), 32'd1);
            chk("replay_pckt", 32'(bus.pckt_o), 32'h3C6);
            step(); step();
            chk("replay_pulses",   32'(wren_cnt - wb),     32'd2);
            chk("replay_drop_cnt", 32'(bus.drop_cnt_o),    32'd0);
            chk("replay_idle",     32'(bus.busy_o),        32'd0);

            // exhausted retries
            do_reset();
            wb = wren_cnt; db = drop_seen;
            set_slot(1, 8'h5A, 2'd0, 2'd2);
            bus.req_i = 4'b0010;
            bus.noc_ovrflw_i = 1'b1;
            step();
            bus.req_i = '0;
            repeat (12) step();
            bus.noc_ovrflw_i = 1'b0;
            chk("exh_pulses",   32'(wren_cnt - wb),   32'd4);
            chk("exh_drops",    32'(drop_seen - db),  32'd1);
            chk("exh_drop_cnt", 32'(bus.drop_cnt_o),  32'd1);
            chk("exh_pckt",     32'(bus.pckt_o),      32'h5A2);
            set_slot(2, 8'h99, 2'd2, 2'd2);
            bus.req_i = 4'b0110;
            @(negedge clk); #1;
            chk("exh_ptr_gnt", 32'(bus.gnt_o), 32'h4);
            step();
            bus.req_i = '0;
            step(); step();

            // reset while replaying
            do_reset();
            set_slot(2, 8'hC3, 2'd1, 2'd1);
            bus.req_i = 4'b0100;
            step();
            bus.req_i = '0;
            bus.noc_ovrflw_i = 1'b1;
            step();
            bus.noc_ovrflw_i = 1'b0;
            bus.noc_full_i = 1'b1;
            step(); step();
            chk("mid_busy", 32'(bus.busy_o), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_busy",     32'(bus.busy_o),     32'd0);
            chk("mid_rst_wren",     32'(bus.wren_o),     32'd0);
            chk("mid_rst_pckt",     32'(bus.pckt_o),     32'd0);
            chk("mid_rst_drop",     32'(bus.drop_o),     32'd0);
            chk("mid_rst_drop_cnt", 32'(bus.drop_cnt_o), 32'd0);
            step();
            bus.noc_full_i = 1'b0;
            set_slot(0, 8'h01, 2'd0, 2'd0);
            set_slot(3, 8'h33, 2'd2, 2'd1);
            bus.req_i = 4'b1001;
            rst_n = 1'b1;
            @(negedge clk); #1;
            chk("mid_fresh_gnt", 32'(bus.gnt_o), 32'h1);
            step();
            bus.req_i = '0;
            step(); step();
         end
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
